serial_adder_arbiter: RTL and testbench

Two-requester arbiter and sequencer for a shared WIDTH-bit bit-serial adder. Latches one requester's operands, issues a single start pulse to the adder, waits a fixed latency, then captures sum/carry. It returns the result with a one-cycle done pulse to the granted requester. The arbiter sits between two client blocks and the adder instance; the adder itself is external.

---
 rtl/serial_adder_arbiter.sv | 112 +++++++++++
 tb/tb_serial_adder_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_arbiter.sv
// Two-requester arbiter/sequencer for an external bit-serial adder: latch, start, wait LAT, capture.
// Define SERIAL_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
//
// state | meaning
// IDLE  | waiting for req0/req1; winner's operands latched on exit
// START | add_start pulse, wait counter loaded
// WAIT  | counting down adder latency; capture on zero
// DONE  | done pulse to granted requester, pointer update
module serial_adder_arbiter #(
  parameter int WIDTH = 4,
  parameter int LAT   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             cin0,
  input  logic             cin1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             busy,
  output logic             add_start,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t          state;
  logic            grant;
  logic [CW-1:0]   cnt;
  logic            pick1;

`ifdef SERIAL_ARB_FIXED_PRIO_EN
  assign pick1 = req1 & ~req0;
`else
  logic ptr;  // last-served requester
  assign pick1 = req1 & (~req0 | ~ptr);
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      grant     <= 1'b0;
      cnt       <= '0;
      add_start <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      busy      <= 1'b0;
      res_sum   <= '0;
      res_cout  <= 1'b0;
      add_a     <= '0;
      add_b     <= '0;
      add_cin   <= 1'b0;
`ifndef SERIAL_ARB_FIXED_PRIO_EN
      ptr       <= 1'b1;
`endif
    end else begin
      add_start <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            grant     <= pick1;
            add_a     <= pick1 ? a1 : a0;
            add_b     <= pick1 ? b1 : b0;
            add_cin   <= pick1 ? cin1 : cin0;
            add_start <= 1'b1;
            busy      <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          cnt   <= CW'(LAT - 1);
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == '0) begin
            res_sum  <= add_sum;
            res_cout <= add_cout;
            done0    <= ~grant;
            done1    <= grant;
            state    <= DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          busy  <= 1'b0;
`ifndef SERIAL_ARB_FIXED_PRIO_EN
          ptr   <= grant;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_arbiter.sv
// Bench for serial_adder_arbiter: behavioural adder, timeline reference model, directed + random stimulus.
// Honours SERIAL_ARB_FIXED_PRIO_EN for the expected arbitration order.
module tb_serial_adder_arbiter;

  localparam int WIDTH = 4;
  localparam int LAT   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0, req1;
  logic [WIDTH-1:0] a0, b0, a1, b1;
  logic             cin0, cin1;
  logic             done0, done1;
  logic [WIDTH-1:0] res_sum;
  logic             res_cout;
  logic             busy;
  logic             add_start;
  logic [WIDTH-1:0] add_a, add_b;
  logic             add_cin;
  logic [WIDTH-1:0] add_sum = '0;
  logic             add_cout = 1'b0;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  serial_adder_arbiter #(.WIDTH(WIDTH), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .cin0(cin0), .cin1(cin1),
    .done0(done0), .done1(done1),
    .res_sum(res_sum), .res_cout(res_cout),
    .busy(busy), .add_start(add_start),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // adder model and reference model share one edge counter
  longint           cyc = 0;
  longint           due = 0;
  longint           ms  = 0;
  logic [WIDTH:0]   s;
  bit               m_act = 1'b0;
  bit               m_w = 1'b0;
  bit               m_last = 1'b1;
  logic [WIDTH:0]   m_sum = '0;
  logic             e_start = 0, e_busy = 0, e_d0 = 0, e_d1 = 0, e_cout = 0, e_cin = 0;
  logic [WIDTH-1:0] e_res = '0, e_a = '0, e_b = '0;

  always @(posedge clk) begin
    cyc++;
    // adder: result valid only for the edge LAT after add_start was sampled, garbage otherwise
    s = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
    if (add_start) due = cyc + LAT;
    if (cyc + 1 == due) begin
      add_sum  <= s[WIDTH-1:0];
      add_cout <= s[WIDTH];
    end else begin
      add_sum  <= ~s[WIDTH-1:0];
      add_cout <= ~s[WIDTH];
    end

    if (!rst) begin
      m_act = 1'b0; m_last = 1'b1;
      e_start = 0; e_busy = 0; e_d0 = 0; e_d1 = 0;
      e_res = '0; e_cout = 0; e_a = '0; e_b = '0; e_cin = 0;
    end else begin
      if (!m_act) begin
        if (req0 | req1) begin
`ifdef SERIAL_ARB_FIXED_PRIO_EN
          m_w = !req0;
`else
          m_w = (req0 && req1) ? !m_last : req1;
`endif
          m_act = 1'b1;
          ms    = cyc;
          e_a   = m_w ? a1 : a0;
          e_b   = m_w ? b1 : b0;
          e_cin = m_w ? cin1 : cin0;
          m_sum = {1'b0, e_a} + {1'b0, e_b} + {{WIDTH{1'b0}}, e_cin};
        end
      end else if (cyc == ms + LAT + 2) begin
        m_act = 1'b0;
      end
      e_start = m_act && (cyc == ms);
      e_busy  = m_act;
      e_d0 = 0; e_d1 = 0;
      if (m_act && cyc == ms + LAT + 1) begin
        e_d0   = !m_w;
        e_d1   = m_w;
        e_res  = m_sum[WIDTH-1:0];
        e_cout = m_sum[WIDTH];
        m_last = m_w;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("done0", 32'(done0), 32'(e_d0));
      chk("done1", 32'(done1), 32'(e_d1));
      chk("add_start", 32'(add_start), 32'(e_start));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("res_sum", 32'(res_sum), 32'(e_res));
      chk("res_cout", 32'(res_cout), 32'(e_cout));
      chk("add_a", 32'(add_a), 32'(e_a));
      chk("add_b", 32'(add_b), 32'(e_b));
      chk("add_cin", 32'(add_cin), 32'(e_cin));
    end
  end

  // who: 0 -> done0, 1 -> done1, 2 -> either; n = negedges waited
  task automatic wait_done(input int who, output int n);
    logic hit;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      hit = (who == 0) ? done0 : (who == 1) ? done1 : (done0 | done1);
    end while (!hit && n < 40);
    chk("wait_done", 32'(hit), 32'd1);
  endtask

  int n;
  int ndone;
  int exp_who;

  initial begin
    rst = 1'b0; req0 = 0; req1 = 0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; cin0 = 0; cin1 = 0;
    @(posedge clk);
    chk_on = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sum", 32'(res_sum), 32'd0);
    rst = 1'b1;

    // single request from requester 0
    req0 = 1; a0 = 4'b0011; b0 = 4'b1011; cin0 = 0;
    wait_done(0, n);
    chk("single_lat", 32'(n), 32'(LAT + 2));
    chk("single_sum", 32'(res_sum), 32'b1110);
    chk("single_cout", 32'(res_cout), 32'd0);
    req0 = 0;
    @(negedge clk);

    // carry out from requester 1
    req1 = 1; a1 = 4'b1111; b1 = 4'b0001; cin1 = 1;
    wait_done(1, n);
    chk("carry_lat", 32'(n), 32'(LAT + 2));
    chk("carry_sum", 32'(res_sum), 32'b0001);
    chk("carry_cout", 32'(res_cout), 32'd1);
    req1 = 0;
    @(negedge clk);

    // tie held across four arbitrations
    req0 = 1; a0 = 4'b0011; b0 = 4'b0001; cin0 = 0;
    req1 = 1; a1 = 4'b0011; b1 = 4'b1011; cin1 = 0;
    for (int k = 0; k < 4; k++) begin
      wait_done(2, n);
`ifdef SERIAL_ARB_FIXED_PRIO_EN
      exp_who = 0;
`else
      exp_who = k % 2;
`endif
      chk("tie_who", 32'(done1), 32'(exp_who));
      chk("tie_sum", 32'(res_sum), (exp_who == 1) ? 32'b1110 : 32'b0100);
      if (k == 0) chk("tie_first", 32'(n), 32'(LAT + 2));
      else        chk("tie_gap", 32'(n), 32'(LAT + 3));
    end
    req0 = 0; req1 = 0;
    @(negedge clk);

    // requester drops and changes operands during WAIT
    req0 = 1; a0 = 4'd5; b0 = 4'd6; cin0 = 1;
    repeat (3) @(negedge clk);
    req0 = 0; a0 = 4'hF;
    wait_done(0, n);
    chk("drop_lat", 32'(n), 32'(LAT + 2 - 3));
    chk("drop_sum", 32'(res_sum), 32'b1100);
    chk("drop_cout", 32'(res_cout), 32'd0);
    @(negedge clk);

    // reset during WAIT aborts the operation
    req0 = 1; a0 = 4'd2; b0 = 4'd2; cin0 = 0;
    repeat (3) @(negedge clk);
    rst = 0; req0 = 0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_sum", 32'(res_sum), 32'd0);
    chk("abort_a", 32'(add_a), 32'd0);
    rst = 1;
    ndone = 0;
    repeat (LAT + 4) begin
      @(negedge clk);
      if (done0 | done1) ndone++;
    end
    chk("abort_nodone", 32'(ndone), 32'd0);
    req0 = 1; a0 = 4'd7; b0 = 4'd8; cin0 = 0;
    wait_done(0, n);
    chk("post_rst_lat", 32'(n), 32'(LAT + 2));
    chk("post_rst_sum", 32'(res_sum), 32'b1111);
    req0 = 0;
    @(negedge clk);

    // random traffic, occasional protocol drops and resets
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      if (!req0) begin
        if ($urandom_range(0, 2) == 0) begin
          req0 = 1; a0 = 4'($urandom); b0 = 4'($urandom); cin0 = 1'($urandom);
        end
      end else if (done0 || $urandom_range(0, 39) == 0) begin
        if ($urandom_range(0, 1) == 1) req0 = 0;
        else begin a0 = 4'($urandom); b0 = 4'($urandom); cin0 = 1'($urandom); end
      end
      if (!req1) begin
        if ($urandom_range(0, 2) == 0) begin
          req1 = 1; a1 = 4'($urandom); b1 = 4'($urandom); cin1 = 1'($urandom);
        end
      end else if (done1 || $urandom_range(0, 39) == 0) begin
        if ($urandom_range(0, 1) == 1) req1 = 0;
        else begin a1 = 4'($urandom); b1 = 4'($urandom); cin1 = 1'($urandom); end
      end
    end
    rst = 1; req0 = 0; req1 = 0;
    repeat (LAT + 4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
